// File: rtl/uff_pkg.sv
// Shared mode encoding for the universal flip-flop bank.
package uff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_D  = 2'b00;
  localparam mode_t MODE_T  = 2'b01;
  localparam mode_t MODE_SR = 2'b10;
  localparam mode_t MODE_JK = 2'b11;

endpackage

// File: rtl/uff_cell.sv
// One bit of the bank: combinational next state and illegal S=R=1 detect.
module uff_cell
  import uff_pkg::*;
(
  input  logic  q,
  input  logic  a,
  input  logic  b,
  input  mode_t mode,
  input  logic  en,
  input  logic  load,
  input  logic  load_val,
  output logic  q_next,
  output logic  sr_ill
);

  always_comb begin
    q_next = q;
    sr_ill = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      case (mode)
        MODE_D: q_next = a;
        MODE_T: q_next = q ^ a;
        MODE_SR: begin
          case ({a, b})
            2'b00: q_next = q;
            2'b10: q_next = 1'b1;
            2'b01: q_next = 1'b0;
            2'b11: sr_ill = 1'b1;  // illegal: hold and flag
          endcase
        end
        MODE_JK: begin
          case ({a, b})
            2'b00: q_next = q;
            2'b10: q_next = 1'b1;
            2'b01: q_next = 1'b0;
            2'b11: q_next = ~q;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/universal_ff_bank.sv
// WIDTH-bit register bank with run-time D/T/SR/JK behaviour per bit.
// Optional saturating bit-change counter enabled by macro UFF_CHG_CNT_EN.
module universal_ff_bank
  import uff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_wr,
  input  logic [1:0]       mode_in,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [1:0]       mode_q,
  output logic [WIDTH-1:0] sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] sr_ill;
  logic [WIDTH-1:0] sr_err_reg;
  logic [WIDTH-1:0] sr_err_next;
  mode_t            mode_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      uff_cell u_cell (
        .q        (q_reg[gi]),
        .a        (a[gi]),
        .b        (b[gi]),
        .mode     (mode_reg),
        .en       (en),
        .load     (load),
        .load_val (load_val[gi]),
        .q_next   (q_next[gi]),
        .sr_ill   (sr_ill[gi])
      );
    end
  endgenerate

  // A fresh illegal condition outranks a simultaneous clear.
  assign sr_err_next = (sr_err_reg & ~{WIDTH{err_clr}}) | sr_ill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg      <= '0;
      mode_reg   <= MODE_D;
      sr_err_reg <= '0;
    end else begin
      q_reg      <= q_next;
      sr_err_reg <= sr_err_next;
      if (mode_wr) begin
        mode_reg <= mode_t'(mode_in);
      end
    end
  end

  assign q      = q_reg;
  assign qn     = ~q_reg;
  assign mode_q = mode_reg;
  assign sr_err = sr_err_reg;

`ifdef UFF_CHG_CNT_EN
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [PC_W-1:0]  pc_next;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    pc_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc_next = pc_next + PC_W'(q_next[i] ^ q_reg[i]);
    end
    // Widened sum so the saturation compare never sees a wrapped value.
    sum_next = SUM_W'(cnt_reg) + SUM_W'(pc_next);
    cnt_next = (sum_next > CNT_MAX) ? {CNT_W{1'b1}} : sum_next[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign chg_cnt = cnt_reg;
`else
  assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_universal_ff_bank.sv
// Self-checking bench: directed scenarios plus randomized run against a behavioural model.
module tb_universal_ff_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_wr;
  logic [1:0]  mode_in;
  logic        en;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        err_clr;

  logic [7:0]  q, qn, sr_err;
  logic [1:0]  mode_q;
  logic [15:0] chg_cnt;
  logic [7:0]  q_s, qn_s, sr_err_s;
  logic [1:0]  mode_q_s;
  logic [3:0]  chg_cnt_s;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] mq;
  logic [7:0] merr;
  logic [1:0] mmode;
  int         mcnt;

  always #5 clk = ~clk;

  universal_ff_bank #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode_wr(mode_wr), .mode_in(mode_in), .en(en),
    .load(load), .load_val(load_val), .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qn(qn), .mode_q(mode_q), .sr_err(sr_err), .chg_cnt(chg_cnt)
  );

  // Narrow-counter copy on the same stimulus, to exercise saturation.
  universal_ff_bank #(.WIDTH(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .mode_wr(mode_wr), .mode_in(mode_in), .en(en),
    .load(load), .load_val(load_val), .a(a), .b(b), .err_clr(err_clr),
    .q(q_s), .qn(qn_s), .mode_q(mode_q_s), .sr_err(sr_err_s), .chg_cnt(chg_cnt_s)
  );

  function automatic int exp_cnt(int c, int maxv);
`ifdef UFF_CHG_CNT_EN
    return (c > maxv) ? maxv : c;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mq = 8'h00; merr = 8'h00; mmode = 2'b00; mcnt = 0;
  endtask

  task automatic idle_inputs();
    mode_wr = 0; mode_in = 0; en = 0; load = 0; load_val = 0; a = 0; b = 0; err_clr = 0;
  endtask

  // One clock edge; model advances from the inputs held across the edge.
  task automatic tick();
    logic [7:0] nq;
    logic [7:0] nerr;
    nq   = mq;
    nerr = err_clr ? 8'h00 : merr;
    for (int i = 0; i < 8; i++) begin
      if (load) nq[i] = load_val[i];
      else if (en) begin
        case (mmode)
          2'd0: nq[i] = a[i];
          2'd1: nq[i] = mq[i] ^ a[i];
          2'd2: begin
            if (a[i] && b[i]) nerr[i] = 1'b1;
            else if (a[i]) nq[i] = 1'b1;
            else if (b[i]) nq[i] = 1'b0;
          end
          default: begin
            if (a[i] && b[i]) nq[i] = ~mq[i];
            else if (a[i]) nq[i] = 1'b1;
            else if (b[i]) nq[i] = 1'b0;
          end
        endcase
      end
    end
    @(posedge clk);
    #1;
    mcnt += $countones(nq ^ mq);
    mq   = nq;
    merr = nerr;
    if (mode_wr) mmode = mode_in;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    en = 1; a = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (q !== 8'h00 || qn !== 8'hFF) begin
      errors++; $display("FAIL reset_q: q=%h qn=%h required q=00 qn=ff", q, qn);
    end
    checks++;
    if (mode_q !== 2'b00 || sr_err !== 8'h00 || chg_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_state: mode_q=%0d sr_err=%h chg_cnt=%0d required 0/00/0", mode_q, sr_err, chg_cnt);
    end
  endtask

  task automatic test_d();
    rst = 1'b1;
    tick();
    checks++;
    if (q !== 8'hA5 || qn !== 8'h5A) begin
      errors++; $display("FAIL d_mode: q=%h qn=%h required q=a5 qn=5a", q, qn);
    end
    checks++;
    if (chg_cnt !== 16'(exp_cnt(4, 65535))) begin
      errors++; $display("FAIL d_cnt: chg_cnt=%0d required %0d", chg_cnt, exp_cnt(4, 65535));
    end
    $display("d: q=%h qn=%h", q, qn);
  endtask

  task automatic test_t();
    logic [7:0] exp_seq [3];
    int base;
    exp_seq[0] = 8'hF0; exp_seq[1] = 8'h0F; exp_seq[2] = 8'hF0;
    idle_inputs();
    load = 1; load_val = 8'h0F; mode_wr = 1; mode_in = 2'b01; en = 1; a = 8'hFF;
    tick();
    checks++;
    if (q !== 8'h0F || mode_q !== 2'b01) begin
      errors++; $display("FAIL t_setup: q=%h mode_q=%0d required 0f/1", q, mode_q);
    end
    base = mcnt;
    load = 0; mode_wr = 0; en = 1; a = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (q !== exp_seq[k]) begin
        errors++; $display("FAIL t_toggle%0d: q=%h required %h", k, q, exp_seq[k]);
      end
      $display("t: step %0d q=%h", k, q);
    end
    checks++;
    if (chg_cnt !== 16'(exp_cnt(base + 24, 65535))) begin
      errors++; $display("FAIL t_cnt: chg_cnt=%0d required %0d", chg_cnt, exp_cnt(base + 24, 65535));
    end
  endtask

  task automatic test_sr_illegal();
    idle_inputs();
    mode_wr = 1; mode_in = 2'b10; load = 1; load_val = 8'h00;
    tick();
    idle_inputs();
    en = 1; a = 8'h81; b = 8'h01;
    tick();
    checks++;
    if (q !== 8'h80 || sr_err !== 8'h01) begin
      errors++; $display("FAIL sr_set: q=%h sr_err=%h required 80/01", q, sr_err);
    end
    a = 8'h03; b = 8'h03;
    tick();
    checks++;
    if (q !== 8'h80 || sr_err !== 8'h03) begin
      errors++; $display("FAIL sr_illegal: q=%h sr_err=%h required 80/03", q, sr_err);
    end
    a = 8'h02; b = 8'h02; err_clr = 1;
    tick();
    checks++;
    if (q !== 8'h80 || sr_err !== 8'h02) begin
      errors++; $display("FAIL sr_clr_race: q=%h sr_err=%h required 80/02", q, sr_err);
    end
    $display("sr: q=%h sr_err=%h", q, sr_err);
    idle_inputs();
    load = 1; load_val = 8'h55;
    tick();
    checks++;
    if (q !== 8'h55 || sr_err !== 8'h02) begin
      errors++; $display("FAIL sr_load_keeps_err: q=%h sr_err=%h required 55/02", q, sr_err);
    end
  endtask

  task automatic test_jk();
    idle_inputs();
    mode_wr = 1; mode_in = 2'b11; load = 1; load_val = 8'h0C;
    tick();
    idle_inputs();
    en = 1; a = 8'h0A; b = 8'h06;
    tick();
    checks++;
    if (q !== 8'h0A) begin
      errors++; $display("FAIL jk_table: q=%h required 0a", q);
    end
    $display("jk: q=%h", q);
  endtask

  task automatic test_priority_mode();
    idle_inputs();
    load = 1; en = 1; load_val = 8'h3C; a = 8'hFF; b = 8'hFF;
    tick();
    checks++;
    if (q !== 8'h3C) begin
      errors++; $display("FAIL load_priority: q=%h required 3c", q);
    end
    idle_inputs();
    mode_wr = 1; mode_in = 2'b01; en = 1; a = 8'h0F; b = 8'h03;
    tick();
    checks++;
    if (q !== 8'h3F || mode_q !== 2'b01) begin
      errors++; $display("FAIL mode_old_rule: q=%h mode_q=%0d required 3f/1", q, mode_q);
    end
    mode_wr = 0; a = 8'h0F; b = 8'h00;
    tick();
    checks++;
    if (q !== 8'h30) begin
      errors++; $display("FAIL mode_new_rule: q=%h required 30", q);
    end
    $display("mode: q=%h mode_q=%0d", q, mode_q);
  endtask

  task automatic test_async_sat();
    idle_inputs();
    #0 rst = 1'b0;          // already 1 ns past an edge: mid-cycle
    #2;
    model_reset();
    checks++;
    if (q !== 8'h00 || qn !== 8'hFF || sr_err !== 8'h00 || chg_cnt !== 16'h0 || mode_q !== 2'b00) begin
      errors++; $display("FAIL async_reset: q=%h qn=%h sr_err=%h chg_cnt=%0d mode_q=%0d required 00/ff/00/0/0",
                         q, qn, sr_err, chg_cnt, mode_q);
    end
    #1 rst = 1'b1;
    mode_wr = 1; mode_in = 2'b01;
    tick();
    mode_wr = 0; en = 1; a = 8'hFF;
    repeat (2) tick();
    checks++;
    if (chg_cnt_s !== 4'(exp_cnt(16, 15)) || chg_cnt !== 16'(exp_cnt(16, 65535))) begin
      errors++; $display("FAIL saturate: cnt4=%0d cnt16=%0d required %0d/%0d",
                         chg_cnt_s, chg_cnt, exp_cnt(16, 15), exp_cnt(16, 65535));
    end
    tick();
    checks++;
    if (chg_cnt_s !== 4'(exp_cnt(24, 15))) begin
      errors++; $display("FAIL saturate_hold: cnt4=%0d required %0d", chg_cnt_s, exp_cnt(24, 15));
    end
    $display("sat: cnt4=%0d cnt16=%0d", chg_cnt_s, chg_cnt);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      mode_wr  = ($urandom_range(0, 5) == 0);
      mode_in  = 2'($urandom_range(0, 3));
      en       = ($urandom_range(0, 4) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      err_clr  = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (q !== mq || qn !== ~mq || mode_q !== mmode || sr_err !== merr ||
          chg_cnt !== 16'(exp_cnt(mcnt, 65535)) || chg_cnt_s !== 4'(exp_cnt(mcnt, 15))) begin
        errors++;
        $display("FAIL random%0d: q=%h mode=%0d err=%h cnt=%0d cnt4=%0d required q=%h mode=%0d err=%h cnt=%0d cnt4=%0d",
                 n, q, mode_q, sr_err, chg_cnt, chg_cnt_s, mq, mmode, merr,
                 exp_cnt(mcnt, 65535), exp_cnt(mcnt, 15));
      end
    end
    $display("random: 300 transactions, final q=%h", q);
  endtask

  initial begin
    test_reset();
    test_d();
    test_t();
    test_sr_illegal();
    test_jk();
    test_priority_mode();
    test_async_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
